cpu_bus_arbiter: RTL

//  Shares the single CPU-side port of the AXI bridge between the instruction-fetch
//  (I) port and the load/store (D) port. Grants one transaction at a time, drives the

---
 rtl/cpu_bus_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
//
// Shares the single CPU-side port of the AXI bridge between the instruction
// fetch port (I, read only) and the load/store port (D, read or write). Only
// one transaction is outstanding at a time. The winner's address, write data
// and byte valids are latched on the grant cycle. Every bridge-facing output
// comes straight from those registers, and so do all acks and read data.
//
// Parameters
//   ADDR_W  address width of every port
//   DATA_W  data width; byte-valid width is DATA_W/8
//   RR_EN   1 = round-robin between I and D, 0 = D always wins when requesting
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   i_rd_req / i_rd_addr             I read request (held until i_rd_ack)
//   i_rd_ack / i_rd_data             I completion pulse and registered read data
//   d_rd_req / d_wr_req              D read / write request (held until d_ack)
//   d_addr / d_wdata / d_be          D address, write data, byte valids
//   d_ack / d_rd_data                D completion pulse and registered read data
//   m_r_addr_valid/m_r_addr/
//   m_r_byte_valid                   bridge read request level, address, bytes
//   m_r_data_valid / m_r_data        bridge read data (valid held until request drops)
//   m_w_addr_valid/m_w_addr/
//   m_w_data/m_w_byte_valid          bridge write request level, address, data, bytes
//   m_w_busy                         bridge write busy
// -----------------------------------------------------------------------------
module cpu_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RR_EN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rd_req,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic                  i_rd_ack,
  output logic [DATA_W-1:0]     i_rd_data,
  input  logic                  d_rd_req,
  input  logic                  d_wr_req,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rd_data,
  output logic                  m_r_addr_valid,
  output logic [ADDR_W-1:0]     m_r_addr,
  output logic [DATA_W/8-1:0]   m_r_byte_valid,
  input  logic                  m_r_data_valid,
  input  logic [DATA_W-1:0]     m_r_data,
  output logic                  m_w_addr_valid,
  output logic [ADDR_W-1:0]     m_w_addr,
  output logic [DATA_W-1:0]     m_w_data,
  output logic [DATA_W/8-1:0]   m_w_byte_valid,
  input  logic                  m_w_busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_REL  = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_REL  = 3'd4,
    ST_WR_DONE = 3'd5
  } state_e;

  state_e              state_q;
  logic                rr_q;        // 0: I has priority on a tie, 1: D has priority
  logic                owner_d_q;   // 1: current read belongs to D
  logic                busy_seen_q; // bridge has raised m_w_busy for this write
  logic                i_rd_ack_q;
  logic                d_ack_q;
  logic [DATA_W-1:0]   i_rd_data_q;
  logic [DATA_W-1:0]   d_rd_data_q;
  logic                m_r_addr_valid_q;
  logic [ADDR_W-1:0]   m_r_addr_q;
  logic [BE_W-1:0]     m_r_be_q;
  logic                m_w_addr_valid_q;
  logic [ADDR_W-1:0]   m_w_addr_q;
  logic [DATA_W-1:0]   m_w_data_q;
  logic [BE_W-1:0]     m_w_be_q;

  logic                d_req;
  logic                grant_any;
  logic                grant_d;

  // Arbitration decision, only acted upon while the FSM is idle.
  always_comb begin
    d_req     = d_rd_req | d_wr_req;
    grant_any = i_rd_req | d_req;
    if (RR_EN != 0) begin
      // A lone requester always wins; on a tie the pointer decides.
      grant_d = d_req & (~i_rd_req | rr_q);
    end else begin
      grant_d = d_req;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      rr_q             <= 1'b0;
      owner_d_q        <= 1'b0;
      busy_seen_q      <= 1'b0;
      i_rd_ack_q       <= 1'b0;
      d_ack_q          <= 1'b0;
      i_rd_data_q      <= {DATA_W{1'b0}};
      d_rd_data_q      <= {DATA_W{1'b0}};
      m_r_addr_valid_q <= 1'b0;
      m_r_addr_q       <= {ADDR_W{1'b0}};
      m_r_be_q         <= {BE_W{1'b0}};
      m_w_addr_valid_q <= 1'b0;
      m_w_addr_q       <= {ADDR_W{1'b0}};
      m_w_data_q       <= {DATA_W{1'b0}};
      m_w_be_q         <= {BE_W{1'b0}};
    end else begin
      // Acks are single-cycle pulses unless a state below raises them.
      i_rd_ack_q <= 1'b0;
      d_ack_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            // Pointer moves to the port that did not win this grant.
            rr_q        <= ~grant_d;
            owner_d_q   <= grant_d;
            busy_seen_q <= 1'b0;
            if (grant_d && d_wr_req) begin
              // A write takes precedence when D raises both requests.
              m_w_addr_q       <= d_addr;
              m_w_data_q       <= d_wdata;
              m_w_be_q         <= d_be;
              m_w_addr_valid_q <= 1'b1;
              state_q          <= ST_WR;
            end else if (grant_d) begin
              m_r_addr_q       <= d_addr;
              m_r_be_q         <= d_be;
              m_r_addr_valid_q <= 1'b1;
              state_q          <= ST_RD;
            end else begin
              // Instruction fetches always read the full word.
              m_r_addr_q       <= i_rd_addr;
              m_r_be_q         <= {BE_W{1'b1}};
              m_r_addr_valid_q <= 1'b1;
              state_q          <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (m_r_data_valid) begin
            if (owner_d_q) begin
              d_rd_data_q <= m_r_data;
              d_ack_q     <= 1'b1;
            end else begin
              i_rd_data_q <= m_r_data;
              i_rd_ack_q  <= 1'b1;
            end
            m_r_addr_valid_q <= 1'b0;
            state_q          <= ST_RD_REL;
          end
        end
        ST_RD_REL: begin
          // Bridge keeps data valid until it notices the request dropped.
          if (!m_r_data_valid) begin
            state_q <= ST_IDLE;
          end
        end
        ST_WR: begin
          // Completion is the falling edge of busy, not merely busy low.
          if (m_w_busy) begin
            busy_seen_q <= 1'b1;
          end else if (busy_seen_q) begin
            m_w_addr_valid_q <= 1'b0;
            d_ack_q          <= 1'b1;
            state_q          <= ST_WR_REL;
          end
        end
        ST_WR_REL: begin
          state_q <= ST_WR_DONE;
        end
        ST_WR_DONE: begin
          // Gives the bridge one cycle to settle back to idle.
          state_q <= ST_IDLE;
        end
        default: begin
          m_r_addr_valid_q <= 1'b0;
          m_w_addr_valid_q <= 1'b0;
          state_q          <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_rd_ack       = i_rd_ack_q;
  assign i_rd_data      = i_rd_data_q;
  assign d_ack          = d_ack_q;
  assign d_rd_data      = d_rd_data_q;
  assign m_r_addr_valid = m_r_addr_valid_q;
  assign m_r_addr       = m_r_addr_q;
  assign m_r_byte_valid = m_r_be_q;
  assign m_w_addr_valid = m_w_addr_valid_q;
  assign m_w_addr       = m_w_addr_q;
  assign m_w_data       = m_w_data_q;
  assign m_w_byte_valid = m_w_be_q;

endmodule
